// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - iterative one-bit-per-cycle shift unit (SLL/SRL/SRA/ROR) with carry and zero flags
module seq_shifter #(
    parameter int N = 8,
    parameter int S = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [S-1:0] shamt,
    input  logic [1:0]   op,
    output logic [N-1:0] y,
    output logic         carry,
    output logic         zero,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic [S-1:0] CNT_ONE = S'(1);

    state_t         state_q, state_d;
    logic [N-1:0]   y_q, y_d;
    logic [S-1:0]   cnt_q, cnt_d;
    logic [1:0]     op_q, op_d;
    logic           carry_q, carry_d;
    logic           zero_q, zero_d;

    // A new request is only taken when no shift is in flight (IDLE or DONE).
    logic           accept;
    assign accept = start && (state_q != ST_SHIFT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE re-enters the operation directly on a new start
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d = (shamt == '0) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // cnt of 0 is unreachable here, but leaving on it avoids a stuck state
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_SHIFT: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath next values: load on accept, one single-bit step per SHIFT cycle, hold otherwise
    always_comb begin
        y_d     = y_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        carry_d = carry_q;
        if (accept) begin
            y_d     = a;
            cnt_d   = shamt;
            op_d    = op;
            carry_d = 1'b0;
        end else if (state_q == ST_SHIFT) begin
            cnt_d = cnt_q - CNT_ONE;
            case (op_q)
                OP_SLL: begin
                    y_d     = {y_q[N-2:0], 1'b0};
                    carry_d = y_q[N-1];
                end
                OP_SRL: begin
                    y_d     = {1'b0, y_q[N-1:1]};
                    carry_d = y_q[0];
                end
                OP_SRA: begin
                    y_d     = {y_q[N-1], y_q[N-1:1]};
                    carry_d = y_q[0];
                end
                OP_ROR: begin
                    y_d     = {y_q[0], y_q[N-1:1]};
                    carry_d = y_q[0];
                end
                default: begin
                    y_d     = y_q;
                    carry_d = carry_q;
                end
            endcase
        end
        // Flag tracks the value being written so it is aligned with y
        zero_d = (y_d == '0);
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= '0;
            cnt_q   <= '0;
            op_q    <= OP_SLL;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign y     = y_q;
    assign carry = carry_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - self-checking bench for seq_shifter
module tb_seq_shifter;

    localparam int N = 8;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] a = '0;
    logic [S-1:0] shamt = '0;
    logic [1:0]   op = 2'b00;
    logic [N-1:0] y;
    logic         carry;
    logic         zero;
    logic         busy;
    logic         done;

    seq_shifter #(.N(N), .S(S)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .shamt (shamt),
        .op    (op),
        .y     (y),
        .carry (carry),
        .zero  (zero),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [2:0] sh;
        logic [1:0] op;
        logic [7:0] y;
        logic       c;
        logic       z;
    } vec_t;

    typedef struct {
        logic [7:0] y;
        logic       c;
        logic       z;
        int         due;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sampled on the falling edge: pop the scoreboard on done, else check busy/idle status
    task automatic check_outputs();
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("y", int'(y), int'(e.y));
                chk("carry", int'(carry), int'(e.c));
                chk("zero", int'(zero), int'(e.z));
                chk("latency_cycle", cyc, e.due);
                chk("busy_in_done", int'(busy), 0);
            end
        end else if (sb.size() > 0) begin
            if (cyc < sb[0].due) begin
                chk("busy_during_shift", int'(busy), 1);
            end else begin
                chk("done_missing", 0, 1);
                void'(sb.pop_front());
            end
        end else begin
            chk("idle_busy", int'(busy), 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic issue(input logic [7:0] ai, input logic [2:0] si, input logic [1:0] oi,
                         input logic [7:0] ey, input logic ec, input logic ez);
        exp_t e;
        start = 1'b1;
        a     = ai;
        shamt = si;
        op    = oi;
        e.y   = ey;
        e.c   = ec;
        e.z   = ez;
        e.due = cyc + 1 + int'(si);
        sb.push_back(e);
        tick();
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // Whole-word reference: shift/rotate by the full amount in one go
    function automatic exp_t model(input logic [7:0] av, input logic [2:0] sv, input logic [1:0] ov);
        exp_t r;
        int   s;
        logic [15:0] dbl;
        s     = int'(sv);
        r.c   = 1'b0;
        r.due = 0;
        dbl   = {av, av};
        case (ov)
            2'b00: begin
                r.y = av << s;
                if (s > 0) r.c = av[8-s];
            end
            2'b01: begin
                r.y = av >> s;
                if (s > 0) r.c = av[s-1];
            end
            2'b10: begin
                r.y = 8'($signed(av) >>> s);
                if (s > 0) r.c = av[s-1];
            end
            default: begin
                r.y = 8'(dbl >> s);
                if (s > 0) r.c = av[s-1];
            end
        endcase
        r.z = (r.y == 8'h00);
        return r;
    endfunction

    vec_t vecs[15];
    exp_t m;

    initial begin
        vecs[0]  = '{8'h81, 3'd1, 2'b00, 8'h02, 1'b1, 1'b0};
        vecs[1]  = '{8'h81, 3'd3, 2'b01, 8'h10, 1'b0, 1'b0};
        vecs[2]  = '{8'h90, 3'd2, 2'b10, 8'hE4, 1'b0, 1'b0};
        vecs[3]  = '{8'hFF, 3'd7, 2'b00, 8'h80, 1'b1, 1'b0};
        vecs[4]  = '{8'h01, 3'd1, 2'b11, 8'h80, 1'b1, 1'b0};
        vecs[5]  = '{8'h01, 3'd1, 2'b01, 8'h00, 1'b1, 1'b1};
        vecs[6]  = '{8'h5A, 3'd0, 2'b00, 8'h5A, 1'b0, 1'b0};
        vecs[7]  = '{8'h5A, 3'd0, 2'b01, 8'h5A, 1'b0, 1'b0};
        vecs[8]  = '{8'h5A, 3'd0, 2'b10, 8'h5A, 1'b0, 1'b0};
        vecs[9]  = '{8'h5A, 3'd0, 2'b11, 8'h5A, 1'b0, 1'b0};
        vecs[10] = '{8'hF0, 3'd4, 2'b00, 8'h00, 1'b1, 1'b1};
        vecs[11] = '{8'h81, 3'd7, 2'b11, 8'h03, 1'b0, 1'b0};
        vecs[12] = '{8'h80, 3'd7, 2'b10, 8'hFF, 1'b0, 1'b0};
        vecs[13] = '{8'h7F, 3'd7, 2'b10, 8'h00, 1'b1, 1'b1};
        vecs[14] = '{8'h00, 3'd0, 2'b01, 8'h00, 1'b0, 1'b1};

        // Reset values
        repeat (2) @(negedge clk);
        chk("reset_y", int'(y), 0);
        chk("reset_carry", int'(carry), 0);
        chk("reset_zero", int'(zero), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst = 1'b0;
        tick();

        // Asynchronous reset in the middle of a shift
        issue(8'hFF, 3'd7, 2'b00, 8'h80, 1'b1, 1'b0);
        tick();
        tick();
        #1 rst = 1'b1;
        #1;
        chk("midrst_y", int'(y), 0);
        chk("midrst_carry", int'(carry), 0);
        chk("midrst_zero", int'(zero), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        sb.delete();
        tick();
        rst = 1'b0;
        tick();

        // Table vectors
        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].a, vecs[i].sh, vecs[i].op, vecs[i].y, vecs[i].c, vecs[i].z);
            drain();
        end

        // Random operands against the whole-word model
        for (int i = 0; i < 24; i++) begin
            logic [7:0] ra;
            logic [2:0] rs;
            logic [1:0] ro;
            ra = 8'($urandom);
            rs = 3'($urandom_range(0, 7));
            ro = 2'($urandom_range(0, 3));
            m  = model(ra, rs, ro);
            issue(ra, rs, ro, m.y, m.c, m.z);
            drain();
        end

        // start held during SHIFT with different operands must be ignored
        issue(8'h81, 3'd3, 2'b01, 8'h10, 1'b0, 1'b0);
        start = 1'b1;
        a     = 8'hFF;
        shamt = 3'd1;
        op    = 2'b00;
        tick();
        tick();
        start = 1'b0;
        drain();

        // Back-to-back: new start in the done cycle
        issue(8'h90, 3'd2, 2'b10, 8'hE4, 1'b0, 1'b0);
        tick();
        tick();
        chk("b2b_queue_empty_at_done", sb.size(), 0);
        issue(8'h01, 3'd1, 2'b11, 8'h80, 1'b1, 1'b0);
        drain();

        // Back-to-back after a zero-length shift
        issue(8'h5A, 3'd0, 2'b00, 8'h5A, 1'b0, 1'b0);
        issue(8'h81, 3'd1, 2'b00, 8'h02, 1'b1, 1'b0);
        drain();

        // Result holds while idle and inputs wiggle
        a     = 8'h33;
        shamt = 3'd5;
        op    = 2'b11;
        tick();
        tick();
        chk("hold_y", int'(y), 8'h02);
        chk("hold_carry", int'(carry), 1);
        chk("hold_zero", int'(zero), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
